// File: rtl/serial_frame_rx_if.sv
// Bus bundle for the serial frame receiver: one qualified serial input bit,
// a registered parallel word with its one-cycle strobe, and the frame/error
// counters plus the FSM state for visibility.
//
// Handshake: there is no backpressure in either direction. data_in is
// consumed on a rising edge only when bit_en=1; bit_en=0 is a hold cycle.
// frame_valid is a single-cycle strobe with no ready. data_out and
// parity_err are stable from that strobe until the next one.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             bit_en;
  logic [WIDTH-1:0] data_out;
  logic             frame_valid;
  logic             parity_err;
  logic [7:0]       frame_count;
  logic [7:0]       err_count;
  logic [1:0]       dbg_state;

  // Receiver side: consumes the serial stream and produces the word.
  modport slave (
    input  data_in,
    input  bit_en,
    output data_out,
    output frame_valid,
    output parity_err,
    output frame_count,
    output err_count,
    output dbg_state
  );

  // Source side: drives the serial stream and observes the results.
  modport master (
    output data_in,
    output bit_en,
    input  data_out,
    input  frame_valid,
    input  parity_err,
    input  frame_count,
    input  err_count,
    input  dbg_state
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a 4-bit sync pattern, collects a
// WIDTH-bit payload MSB-first, checks an even-parity bit and presents the
// word with a one-cycle frame_valid pulse. Frame and parity-error counters
// are kept alongside.
module serial_frame_rx #(
  parameter int         WIDTH = 8,
  parameter logic [3:0] SYNC  = 4'b1011
) (
  input  logic            clk,
  input  logic            reset,
  serial_frame_rx_if.slave bus
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Count value seen while the last payload bit is being sampled.
  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  logic [1:0]       state_q,      state_d;
  logic [3:0]       window_q,     window_d;
  logic [WIDTH-1:0] shreg_q,      shreg_d;
  logic [4:0]       cnt_q,        cnt_d;
  logic [WIDTH-1:0] data_out_q,   data_out_d;
  logic             valid_q,      valid_d;
  logic             perr_q,       perr_d;
  logic [7:0]       fcount_q,     fcount_d;
  logic [7:0]       ecount_q,     ecount_d;

  // Window as it would look after shifting in the current bit; a sync
  // match is decided on this so the match edge is the last sync bit's edge.
  logic [3:0] window_next;
  assign window_next = {window_q[2:0], bus.data_in};

  // Next-state logic; bit_en=0 leaves everything untouched except the strobe.
  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    fcount_d   = fcount_q;
    ecount_d   = ecount_q;

    if (bus.bit_en) begin
      case (state_q)
        ST_HUNT: begin
          window_d = window_next;
          if (window_next == SYNC) begin
            state_d = ST_DATA;
            cnt_d   = 5'd0;
          end
        end
        ST_DATA: begin
          shreg_d = {shreg_q[WIDTH-2:0], bus.data_in};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          data_out_d = shreg_q;
          perr_d     = (^shreg_q) ^ bus.data_in;
          valid_d    = 1'b1;
          fcount_d   = fcount_q + 8'd1;
          if (perr_d && (ecount_q != 8'hFF)) begin
            ecount_d = ecount_q + 8'd1;
          end
          // Fresh window so frame bits can never complete the next sync.
          window_d   = 4'd0;
          state_d    = ST_HUNT;
        end
        default: begin
          state_d  = ST_HUNT;
          window_d = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HUNT;
      window_q   <= 4'd0;
      shreg_q    <= '0;
      cnt_q      <= 5'd0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      fcount_q   <= 8'd0;
      ecount_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      fcount_q   <= fcount_d;
      ecount_q   <= ecount_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.frame_valid = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_count = fcount_q;
  assign bus.err_count   = ecount_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed serial streams, a frame-level model
// that parses the sampled bit history, a per-cycle compare against it, and
// literal checks on the key results.
module tb_serial_frame_rx;

  localparam int         WIDTH = 8;
  localparam logic [3:0] SYNC  = 4'b1011;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_frame_rx_if #(.WIDTH(WIDTH)) bus ();

  serial_frame_rx #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Keeps the bits sampled since reset or since the last frame ended. A
  // frame is complete when the first sync in that history is followed by
  // exactly WIDTH payload bits and one parity bit.
  logic             bits[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_perr;
  logic [7:0]       m_fc;
  logic [7:0]       m_ec;

  function automatic int first_sync_end();
    for (int s = 3; s < bits.size(); s++) begin
      if ({bits[s-3], bits[s-2], bits[s-1], bits[s]} == SYNC) return s;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_perr  = 1'b0;
      m_fc    = 8'd0;
      m_ec    = 8'd0;
    end else begin
      m_valid = 1'b0;
      if (bus.bit_en) begin
        int s;
        bits.push_back(bus.data_in);
        s = first_sync_end();
        if (s >= 0 && bits.size() == s + WIDTH + 2) begin
          logic [WIDTH-1:0] pl;
          int ones;
          pl   = '0;
          ones = 0;
          for (int i = 0; i < WIDTH; i++) begin
            pl = {pl[WIDTH-2:0], bits[s+1+i]};
            if (bits[s+1+i]) ones++;
          end
          if (bits[s+WIDTH+1]) ones++;
          m_data  = pl;
          m_perr  = (ones % 2) != 0;
          m_valid = 1'b1;
          m_fc    = m_fc + 8'd1;
          if (m_perr && m_ec < 8'd255) m_ec = m_ec + 8'd1;
          bits.delete();
        end
      end
    end
  end

  // ---------------- per-cycle compare and pulse log ----------------
  int unsigned pulse_q[$];

  always @(negedge clk) begin
    check("frame_valid", 32'(bus.frame_valid), 32'(m_valid));
    check("data_out",    32'(bus.data_out),    32'(m_data));
    check("parity_err",  32'(bus.parity_err),  32'(m_perr));
    check("frame_count", 32'(bus.frame_count), 32'(m_fc));
    check("err_count",   32'(bus.err_count),   32'(m_ec));
    if (bus.frame_valid === 1'b1) pulse_q.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge and are sampled on the next.
  task automatic drive_bit(input logic b, input logic en);
    bus.data_in = b;
    bus.bit_en  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i], 1'b1);
  endtask

  int unsigned k_edge;

  task automatic send_frame(input logic [WIDTH-1:0] pl, input logic par);
    send_bits(32'(SYNC), 4);
    k_edge = cyc;
    send_bits(32'(pl), WIDTH);
    send_bits(32'(par), 1);
  endtask

  task automatic do_reset();
    bus.bit_en  = 1'b0;
    bus.data_in = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.data_in = 1'b0;
    bus.bit_en  = 1'b0;

    // Reset values: asserted between edges, outputs must clear at once.
    #2 reset = 1'b0;
    #1;
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_data_out",    32'(bus.data_out),    32'd0);
    check("rst_parity_err",  32'(bus.parity_err),  32'd0);
    check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    check("rst_err_count",   32'(bus.err_count),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pulse_q.delete();
    repeat (20) drive_bit(1'b0, 1'b1);
    check("zeros_no_pulse", 32'(pulse_q.size()), 32'd0);
    check("zeros_fcount",   32'(bus.frame_count), 32'd0);

    // Good frame.
    pulse_q.delete();
    send_frame(8'hB5, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("good_pulses",  32'(pulse_q.size()), 32'd1);
    if (pulse_q.size() > 0) check("good_latency", pulse_q[0] - k_edge, 32'd9);
    check("good_data",    32'(bus.data_out),    32'hB5);
    check("good_perr",    32'(bus.parity_err),  32'd0);
    check("good_fcount",  32'(bus.frame_count), 32'd1);
    check("good_ecount",  32'(bus.err_count),   32'd0);

    // Bad parity, result held afterwards.
    send_frame(8'hB5, 1'b0);
    repeat (5) drive_bit(1'b0, 1'b1);
    check("bad_data_held", 32'(bus.data_out),    32'hB5);
    check("bad_perr_held", 32'(bus.parity_err),  32'd1);
    check("bad_ecount",    32'(bus.err_count),   32'd1);
    check("bad_fcount",    32'(bus.frame_count), 32'd2);

    // Overlapping sync lead-in and sync-like payload.
    pulse_q.delete();
    send_bits(32'b101011, 6);
    k_edge = cyc;
    send_bits(32'hBB, 8);
    send_bits(32'd0, 1);
    repeat (12) drive_bit(1'b0, 1'b1);
    check("ovl_pulses",  32'(pulse_q.size()), 32'd1);
    if (pulse_q.size() > 0) check("ovl_latency", pulse_q[0] - k_edge, 32'd9);
    check("ovl_data",    32'(bus.data_out),   32'hBB);
    check("ovl_perr",    32'(bus.parity_err), 32'd0);

    // Back-to-back frames.
    pulse_q.delete();
    send_frame(8'hB5, 1'b1);
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 1'b1);
    check("b2b_pulses", 32'(pulse_q.size()), 32'd2);
    if (pulse_q.size() == 2) check("b2b_spacing", pulse_q[1] - pulse_q[0], 32'd13);
    check("b2b_data", 32'(bus.data_out), 32'h3C);

    // Hold cycles mid-payload delay the pulse by their count.
    pulse_q.delete();
    send_bits(32'(SYNC), 4);
    k_edge = cyc;
    send_bits(32'hB, 4);
    repeat (3) drive_bit(1'b1, 1'b0);
    send_bits(32'h5, 4);
    send_bits(32'd1, 1);
    drive_bit(1'b0, 1'b1);
    check("hold_pulses", 32'(pulse_q.size()), 32'd1);
    if (pulse_q.size() > 0) check("hold_latency", pulse_q[0] - k_edge, 32'd12);
    check("hold_data", 32'(bus.data_out),   32'hB5);
    check("hold_perr", 32'(bus.parity_err), 32'd0);

    // Reset aborts a frame in flight; only the resent frame is reported.
    send_bits(32'(SYNC), 4);
    send_bits(32'hB, 4);
    #2 reset = 1'b0;
    #1;
    check("abort_valid",  32'(bus.frame_valid), 32'd0);
    check("abort_fcount", 32'(bus.frame_count), 32'd0);
    check("abort_data",   32'(bus.data_out),    32'd0);
    pulse_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_frame(8'hB5, 1'b1);
    drive_bit(1'b0, 1'b1);
    check("resend_pulses", 32'(pulse_q.size()), 32'd1);
    check("resend_fcount", 32'(bus.frame_count), 32'd1);
    check("resend_data",   32'(bus.data_out),    32'hB5);

    // Counter limits: frame_count wraps, err_count saturates.
    do_reset();
    pulse_q.delete();
    for (int i = 0; i < 256; i++) send_frame(8'(i), ^(8'(i)));
    drive_bit(1'b0, 1'b1);
    check("wrap_pulses", 32'(pulse_q.size()), 32'd256);
    check("wrap_fcount", 32'(bus.frame_count), 32'd0);
    check("wrap_ecount", 32'(bus.err_count),   32'd0);
    for (int i = 0; i < 257; i++) send_frame(8'hB5, 1'b0);
    drive_bit(1'b0, 1'b1);
    check("sat_ecount", 32'(bus.err_count),   32'd255);
    check("sat_fcount", 32'(bus.frame_count), 32'd1);
    check("sat_perr",   32'(bus.parity_err),  32'd1);

    repeat (3) drive_bit(1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
